// File: rtl/io_store_buffer.sv
// Store buffer between the cpu memory port and the RAM/UART bus: RAM accesses pass
// straight through, I/O writes are queued in order and drained when the UART can take them.
module io_store_buffer #(
   parameter int DEPTH_LOG = 3,
   parameter int DRAIN_GAP = 2
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 cpu_req,
   input  logic                 cpu_wr,
   input  logic [31:0]          cpu_a,
   input  logic [7:0]           cpu_dout,
   output logic                 cpu_stall,
   input  logic                 io_buffer_full,
   output logic [31:0]          mem_a,
   output logic [7:0]           mem_dout,
   output logic                 mem_wr,
   output logic [DEPTH_LOG:0]   fifo_count
);

   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam int GAP_W = (DRAIN_GAP > 1) ? $clog2(DRAIN_GAP) : 1;
   localparam logic [GAP_W-1:0]   GAP_LOAD   = GAP_W'(DRAIN_GAP - 1);
   localparam logic [DEPTH_LOG:0] COUNT_FULL = (DEPTH_LOG + 1)'(DEPTH);

   logic [25:0]          fifo_mem [DEPTH];
   logic [DEPTH_LOG-1:0] head_q, head_d;
   logic [DEPTH_LOG-1:0] tail_q, tail_d;
   logic [DEPTH_LOG:0]   count_q, count_d;
   logic [GAP_W-1:0]     gap_q, gap_d;

   logic        is_io;
   logic        fifo_empty;
   logic        fifo_full;
   logic        gap_zero;
   logic        bus_free;
   logic        push;
   logic        pop;
   logic        load_gap;
   logic [25:0] head_entry;

   assign is_io      = (cpu_a[17:16] == 2'b11);
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == COUNT_FULL);
   assign gap_zero   = (gap_q == '0);
   assign head_entry = fifo_mem[head_q];
   assign fifo_count = count_q;

   always_comb begin
      mem_a     = '0;
      mem_dout  = '0;
      mem_wr    = 1'b0;
      cpu_stall = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      load_gap  = 1'b0;
      bus_free  = 1'b0;
      if (!rdy_in) begin
         cpu_stall = 1'b1;
      end else begin
         bus_free = 1'b1;
         if (cpu_req && !is_io) begin
            mem_a    = cpu_a;
            mem_dout = cpu_dout;
            mem_wr   = cpu_wr;
            bus_free = 1'b0;
         end else if (cpu_req && !cpu_wr) begin
            // An I/O read must not overtake queued writes to the same device.
            if (!fifo_empty) begin
               cpu_stall = 1'b1;
            end else begin
               mem_a    = cpu_a;
               mem_dout = cpu_dout;
               bus_free = 1'b0;
            end
         end else if (cpu_req) begin
            if (fifo_empty && !io_buffer_full && gap_zero) begin
               mem_a    = cpu_a;
               mem_dout = cpu_dout;
               mem_wr   = 1'b1;
               load_gap = 1'b1;
               bus_free = 1'b0;
            end else if (!fifo_full) begin
               push = 1'b1;
            end else begin
               cpu_stall = 1'b1;
            end
         end
         // Drain uses the pre-push occupancy, so a write queued this cycle waits its turn.
         if (bus_free && !fifo_empty && !io_buffer_full && gap_zero) begin
            mem_a    = {14'b0, head_entry[25:8]};
            mem_dout = head_entry[7:0];
            mem_wr   = 1'b1;
            pop      = 1'b1;
            load_gap = 1'b1;
         end
      end
   end

   always_comb begin
      head_d  = pop  ? head_q + 1'b1 : head_q;
      tail_d  = push ? tail_q + 1'b1 : tail_q;
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (load_gap)
         gap_d = GAP_LOAD;
      else if (!gap_zero)
         gap_d = gap_q - 1'b1;
      else
         gap_d = gap_q;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         gap_q   <= '0;
      end else if (rdy_in) begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         gap_q   <= gap_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in && push)
         fifo_mem[tail_q] <= {cpu_a[17:0], cpu_dout};
   end

endmodule

// File: tb/tb_io_store_buffer.sv
// Directed bench for io_store_buffer: pass-through, queueing, drain spacing,
// read ordering, RAM priority, reset and rdy freeze.
module tb_io_store_buffer;

   logic        clk_in;
   logic        rst_in;
   logic        rdy_in;
   logic        cpu_req;
   logic        cpu_wr;
   logic [31:0] cpu_a;
   logic [7:0]  cpu_dout;
   logic        cpu_stall;
   logic        io_buffer_full;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic [3:0]  fifo_count;

   int tests_run;
   int tests_failed;

   // Observation vector: {mem_a, mem_dout, mem_wr, cpu_stall, fifo_count}
   wire [45:0] obs = {mem_a, mem_dout, mem_wr, cpu_stall, fifo_count};

   io_store_buffer #(.DEPTH_LOG(3), .DRAIN_GAP(2)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .cpu_req        (cpu_req),
      .cpu_wr         (cpu_wr),
      .cpu_a          (cpu_a),
      .cpu_dout       (cpu_dout),
      .cpu_stall      (cpu_stall),
      .io_buffer_full (io_buffer_full),
      .mem_a          (mem_a),
      .mem_dout       (mem_dout),
      .mem_wr         (mem_wr),
      .fifo_count     (fifo_count)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic drive(input logic req, input logic wr, input logic [31:0] a, input logic [7:0] d);
      cpu_req  = req;
      cpu_wr   = wr;
      cpu_a    = a;
      cpu_dout = d;
      #1;
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      rdy_in = 1'b1;
      io_buffer_full = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 8'h0);
      tick();
      tick();
      rst_in = 1'b0;
      #1;
      tests_run++;
      if (obs !== 46'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h need %h", obs, 46'h0);
      end else $display("[TB] reset_outputs ok");
   endtask

   task automatic test_ram_passthrough();
      drive(1'b1, 1'b1, 32'h100, 8'h5A);
      tests_run++;
      if (obs !== {32'h100, 8'h5A, 1'b1, 1'b0, 4'd0}) begin
         tests_failed++;
         $display("FAIL ram_write: got %h need %h", obs, {32'h100, 8'h5A, 1'b1, 1'b0, 4'd0});
      end else $display("[TB] ram_write ok");
      tick();
      drive(1'b1, 1'b0, 32'h8001_0200, 8'h00);
      tests_run++;
      if (obs !== {32'h8001_0200, 8'h00, 1'b0, 1'b0, 4'd0}) begin
         tests_failed++;
         $display("FAIL ram_read: got %h need %h", obs, {32'h8001_0200, 8'h00, 1'b0, 1'b0, 4'd0});
      end else $display("[TB] ram_read ok");
      tick();
   endtask

   task automatic test_direct_and_gap();
      drive(1'b1, 1'b1, 32'h30000, 8'h41);
      tests_run++;
      if (obs !== {32'h30000, 8'h41, 1'b1, 1'b0, 4'd0}) begin
         tests_failed++;
         $display("FAIL direct_write: got %h need %h", obs, {32'h30000, 8'h41, 1'b1, 1'b0, 4'd0});
      end else $display("[TB] direct_write ok");
      tick();
      drive(1'b1, 1'b1, 32'h30000, 8'h42);
      tests_run++;
      if (obs !== 46'h0) begin
         tests_failed++;
         $display("FAIL gap_queue: got %h need %h", obs, 46'h0);
      end else $display("[TB] gap_queue ok");
      tick();
      drive(1'b0, 1'b0, 32'h0, 8'h0);
      tests_run++;
      if (obs !== {32'h30000, 8'h42, 1'b1, 1'b0, 4'd1}) begin
         tests_failed++;
         $display("FAIL gap_drain: got %h need %h", obs, {32'h30000, 8'h42, 1'b1, 1'b0, 4'd1});
      end else $display("[TB] gap_drain ok");
      tick();
      tests_run++;
      if (obs !== 46'h0) begin
         tests_failed++;
         $display("FAIL gap_after: got %h need %h", obs, 46'h0);
      end else $display("[TB] gap_after ok");
      tick();
   endtask

   task automatic test_fill_and_drain();
      logic [45:0] exp;
      io_buffer_full = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, 32'h30000, 8'(8'h30 + i));
         exp = {32'h0, 8'h0, 1'b0, 1'b0, 4'(i)};
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("FAIL fill_push%0d: got %h need %h", i, obs, exp);
         end else $display("[TB] fill_push%0d ok", i);
         tick();
      end
      drive(1'b1, 1'b1, 32'h30000, 8'h38);
      tests_run++;
      if (obs !== {32'h0, 8'h0, 1'b0, 1'b1, 4'd8}) begin
         tests_failed++;
         $display("FAIL fill_stall: got %h need %h", obs, {32'h0, 8'h0, 1'b0, 1'b1, 4'd8});
      end else $display("[TB] fill_stall ok");
      tick();
      io_buffer_full = 1'b0;
      #1;
      tests_run++;
      if (obs !== {32'h30000, 8'h30, 1'b1, 1'b1, 4'd8}) begin
         tests_failed++;
         $display("FAIL full_pop_stall: got %h need %h", obs, {32'h30000, 8'h30, 1'b1, 1'b1, 4'd8});
      end else $display("[TB] full_pop_stall ok");
      tick();
      tests_run++;
      if (obs !== {32'h0, 8'h0, 1'b0, 1'b0, 4'd7}) begin
         tests_failed++;
         $display("FAIL ninth_accept: got %h need %h", obs, {32'h0, 8'h0, 1'b0, 1'b0, 4'd7});
      end else $display("[TB] ninth_accept ok");
      tick();
      drive(1'b0, 1'b0, 32'h0, 8'h0);
      for (int k = 1; k <= 8; k++) begin
         exp = {32'h30000, 8'(8'h30 + k), 1'b1, 1'b0, 4'(9 - k)};
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("FAIL drain%0d: got %h need %h", k, obs, exp);
         end else $display("[TB] drain%0d ok", k);
         tick();
         exp = {32'h0, 8'h0, 1'b0, 1'b0, 4'(8 - k)};
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("FAIL drain_gap%0d: got %h need %h", k, obs, exp);
         end else $display("[TB] drain_gap%0d ok", k);
         tick();
      end
   endtask

   task automatic test_io_read_order();
      logic [45:0] exp;
      io_buffer_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 32'h30000, 8'(8'h61 + i));
         tick();
      end
      drive(1'b1, 1'b0, 32'h30004, 8'h00);
      tests_run++;
      if (obs !== {32'h0, 8'h0, 1'b0, 1'b1, 4'd3}) begin
         tests_failed++;
         $display("FAIL read_blocked: got %h need %h", obs, {32'h0, 8'h0, 1'b0, 1'b1, 4'd3});
      end else $display("[TB] read_blocked ok");
      tick();
      io_buffer_full = 1'b0;
      #1;
      for (int j = 0; j < 3; j++) begin
         exp = {32'h30000, 8'(8'h61 + j), 1'b1, 1'b1, 4'(3 - j)};
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("FAIL read_drain%0d: got %h need %h", j, obs, exp);
         end else $display("[TB] read_drain%0d ok", j);
         tick();
         if (j < 2) begin
            exp = {32'h0, 8'h0, 1'b0, 1'b1, 4'(2 - j)};
            tests_run++;
            if (obs !== exp) begin
               tests_failed++;
               $display("FAIL read_wait%0d: got %h need %h", j, obs, exp);
            end else $display("[TB] read_wait%0d ok", j);
            tick();
         end
      end
      tests_run++;
      if (obs !== {32'h30004, 8'h00, 1'b0, 1'b0, 4'd0}) begin
         tests_failed++;
         $display("FAIL read_pass: got %h need %h", obs, {32'h30004, 8'h00, 1'b0, 1'b0, 4'd0});
      end else $display("[TB] read_pass ok");
      tick();
      drive(1'b0, 1'b0, 32'h0, 8'h0);
   endtask

   task automatic test_ram_priority();
      logic [45:0] exp;
      io_buffer_full = 1'b1;
      drive(1'b1, 1'b1, 32'hABC3_0001, 8'h71);
      tick();
      drive(1'b1, 1'b1, 32'h30000, 8'h72);
      tick();
      io_buffer_full = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 32'h200 + 32'(i), 8'h00);
         exp = {32'h200 + 32'(i), 8'h00, 1'b0, 1'b0, 4'd2};
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("FAIL ram_prio%0d: got %h need %h", i, obs, exp);
         end else $display("[TB] ram_prio%0d ok", i);
         tick();
      end
      drive(1'b0, 1'b0, 32'h0, 8'h0);
      tests_run++;
      if (obs !== {32'h30001, 8'h71, 1'b1, 1'b0, 4'd2}) begin
         tests_failed++;
         $display("FAIL prio_resume: got %h need %h", obs, {32'h30001, 8'h71, 1'b1, 1'b0, 4'd2});
      end else $display("[TB] prio_resume ok");
      tick();
      tick();
      tests_run++;
      if (obs !== {32'h30000, 8'h72, 1'b1, 1'b0, 4'd1}) begin
         tests_failed++;
         $display("FAIL prio_second: got %h need %h", obs, {32'h30000, 8'h72, 1'b1, 1'b0, 4'd1});
      end else $display("[TB] prio_second ok");
      tick();
      tick();
   endtask

   task automatic test_reset_and_rdy();
      logic [45:0] exp;
      io_buffer_full = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 32'h30000, 8'(8'h81 + i));
         tick();
      end
      io_buffer_full = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 8'h0);
      tests_run++;
      if (obs !== {32'h30000, 8'h81, 1'b1, 1'b0, 4'd4}) begin
         tests_failed++;
         $display("FAIL mid_drain: got %h need %h", obs, {32'h30000, 8'h81, 1'b1, 1'b0, 4'd4});
      end else $display("[TB] mid_drain ok");
      tick();
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         tests_run++;
         if (obs !== 46'h0) begin
            tests_failed++;
            $display("FAIL post_reset%0d: got %h need %h", i, obs, 46'h0);
         end else $display("[TB] post_reset%0d ok", i);
         tick();
      end
      io_buffer_full = 1'b1;
      drive(1'b1, 1'b1, 32'h30000, 8'h00);
      tick();
      drive(1'b1, 1'b1, 32'h30000, 8'h90);
      tick();
      io_buffer_full = 1'b0;
      rdy_in = 1'b0;
      drive(1'b1, 1'b1, 32'h30000, 8'h99);
      for (int i = 0; i < 5; i++) begin
         exp = {32'h0, 8'h0, 1'b0, 1'b1, 4'd2};
         tests_run++;
         if (obs !== exp) begin
            tests_failed++;
            $display("FAIL rdy_freeze%0d: got %h need %h", i, obs, exp);
         end else $display("[TB] rdy_freeze%0d ok", i);
         tick();
      end
      rdy_in = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 8'h0);
      tests_run++;
      if (obs !== {32'h30000, 8'h00, 1'b1, 1'b0, 4'd2}) begin
         tests_failed++;
         $display("FAIL zero_byte_drain: got %h need %h", obs, {32'h30000, 8'h00, 1'b1, 1'b0, 4'd2});
      end else $display("[TB] zero_byte_drain ok");
      tick();
      rdy_in = 1'b0;
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      rdy_in = 1'b1;
      #1;
      tests_run++;
      if (obs !== 46'h0) begin
         tests_failed++;
         $display("FAIL reset_over_rdy: got %h need %h", obs, 46'h0);
      end else $display("[TB] reset_over_rdy ok");
      tick();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_in       = 1'b1;
      rdy_in       = 1'b1;
      io_buffer_full = 1'b0;
      cpu_req      = 1'b0;
      cpu_wr       = 1'b0;
      cpu_a        = 32'h0;
      cpu_dout     = 8'h0;
      test_reset();
      test_ram_passthrough();
      test_direct_and_gap();
      test_fill_and_drain();
      test_io_read_order();
      test_ram_priority();
      test_reset_and_rdy();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
